// File: rtl/gpio_bank_if.sv
// Register bus between the core and gpio_bank: one-cycle write/read strobes,
// with the read data and its valid pulse returned one cycle later.
interface gpio_bank_if;
    logic [2:0]  bus_addr;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;

    modport master (
        output bus_addr, bus_we, bus_re, bus_wdata,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_addr, bus_we, bus_re, bus_wdata,
        output bus_rdata, bus_rvalid
    );
endinterface

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: direction/data registers, atomic set/clear, synchronised
// inputs and rise/fall W1C interrupts. Define GPIO_DEBOUNCE_EN to add a per-pin debounce filter.
module gpio_bank #(
    parameter int N_GPIO          = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    gpio_bank_if.slave        bus,
    input  logic [N_GPIO-1:0] gpio_i,
    output logic [N_GPIO-1:0] gpio_o,
    output logic [N_GPIO-1:0] gpio_oe,
    output logic              irq
);

    localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_DATA_IN  = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
    localparam logic [2:0] ADDR_STATUS   = 3'd5;
    localparam logic [2:0] ADDR_SET      = 3'd6;
    localparam logic [2:0] ADDR_CLR      = 3'd7;

    logic [N_GPIO-1:0] data_out_q;
    logic [N_GPIO-1:0] dir_q;
    logic [N_GPIO-1:0] rise_en_q;
    logic [N_GPIO-1:0] fall_en_q;
    logic [N_GPIO-1:0] status_q;
    logic [N_GPIO-1:0] in_q;
    logic [N_GPIO-1:0] sync_q [SYNC_STAGES];

    logic [N_GPIO-1:0] sync_last;
    logic [N_GPIO-1:0] accept;
    logic [N_GPIO-1:0] in_next;
    logic [N_GPIO-1:0] rise;
    logic [N_GPIO-1:0] fall;
    logic [N_GPIO-1:0] w1c_mask;
    logic [N_GPIO-1:0] status_next;
    logic [N_GPIO-1:0] wdata_n;
    logic              wr_en;
    logic              rd_en;
    logic [31:0]       rd_mux;

    assign wdata_n   = bus.bus_wdata[N_GPIO-1:0];
    assign wr_en     = bus.bus_we;
    assign rd_en     = bus.bus_re & ~bus.bus_we;
    assign sync_last = sync_q[SYNC_STAGES-1];

    generate
        if (N_GPIO < 32) begin : g_unused_wdata
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^bus.bus_wdata[31:N_GPIO];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= gpio_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    // A pin's counter only runs while the synchronised level disagrees with in_q.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q [N_GPIO];

    always_comb begin
        accept = '0;
        for (int p = 0; p < N_GPIO; p++) begin
            accept[p] = (sync_last[p] != in_q[p]) && (cnt_q[p] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < N_GPIO; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < N_GPIO; p++) begin
                if ((sync_last[p] == in_q[p]) || (cnt_q[p] == CNT_MAX)) begin
                    cnt_q[p] <= '0;
                end else begin
                    cnt_q[p] <= cnt_q[p] + 1'b1;
                end
            end
        end
    end
`else
    assign accept = '1;
`endif

    assign in_next  = (sync_last & accept) | (in_q & ~accept);
    assign rise     = in_next & ~in_q;
    assign fall     = ~in_next & in_q;
    assign w1c_mask = (wr_en && (bus.bus_addr == ADDR_STATUS)) ? wdata_n : '0;

    // A fresh edge is ORed in after the W1C clear, so it survives a same-cycle clear.
    assign status_next = (status_q & ~w1c_mask) | (rise & rise_en_q) | (fall & fall_en_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_q <= '0;
            dir_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            in_q       <= '0;
        end else begin
            in_q     <= in_next;
            status_q <= status_next;
            if (wr_en) begin
                case (bus.bus_addr)
                    ADDR_DATA_OUT: data_out_q <= wdata_n;
                    ADDR_DIR:      dir_q      <= wdata_n;
                    ADDR_RISE_EN:  rise_en_q  <= wdata_n;
                    ADDR_FALL_EN:  fall_en_q  <= wdata_n;
                    ADDR_SET:      data_out_q <= data_out_q | wdata_n;
                    ADDR_CLR:      data_out_q <= data_out_q & ~wdata_n;
                    default:       ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.bus_addr)
            ADDR_DATA_OUT: rd_mux[N_GPIO-1:0] = data_out_q;
            ADDR_DIR:      rd_mux[N_GPIO-1:0] = dir_q;
            ADDR_DATA_IN:  rd_mux[N_GPIO-1:0] = in_q;
            ADDR_RISE_EN:  rd_mux[N_GPIO-1:0] = rise_en_q;
            ADDR_FALL_EN:  rd_mux[N_GPIO-1:0] = fall_en_q;
            ADDR_STATUS:   rd_mux[N_GPIO-1:0] = status_q;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.bus_rdata  <= '0;
            bus.bus_rvalid <= 1'b0;
        end else begin
            bus.bus_rvalid <= rd_en;
            if (rd_en) begin
                bus.bus_rdata <= rd_mux;
            end
        end
    end

    assign gpio_o  = data_out_q;
    assign gpio_oe = dir_q;
    assign irq     = |status_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: directed register table, edge/W1C/reset corner
// sequences and a randomized run compared every cycle against a behavioural model.
module tb_gpio_bank;

    localparam int N   = 10;
    localparam int SS  = 2;
    localparam int DEB = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = SS + 1 + DEB - 1;
`else
    localparam int LAT = SS + 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] gpio_i = '0;
    logic [N-1:0] gpio_o;
    logic [N-1:0] gpio_oe;
    logic         irq;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    gpio_bank_if bus_if ();

    gpio_bank #(
        .N_GPIO(N),
        .SYNC_STAGES(SS),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus_if),
        .gpio_i(gpio_i),
        .gpio_o(gpio_o),
        .gpio_oe(gpio_oe),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: pads are delayed by a sample history, then accepted
    // into the input level once they have disagreed long enough.
    logic [N-1:0] m_out, m_dir, m_rise, m_fall, m_stat, m_in;
    logic [N-1:0] hist [SS];
    logic [N-1:0] synced, new_in, w1c;
    logic [31:0]  m_rdata;
    logic         m_rvalid;
    int           m_cnt [N];

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {22'b0, m_out};
            3'd1:    return {22'b0, m_dir};
            3'd2:    return {22'b0, m_in};
            3'd3:    return {22'b0, m_rise};
            3'd4:    return {22'b0, m_fall};
            3'd5:    return {22'b0, m_stat};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_stat = '0; m_in = '0;
            m_rdata = '0; m_rvalid = 1'b0;
            for (int s = 0; s < SS; s++) hist[s] = '0;
            for (int p = 0; p < N; p++) m_cnt[p] = 0;
        end else begin
            synced = hist[SS-1];
            for (int s = SS - 1; s > 0; s--) hist[s] = hist[s-1];
            hist[0] = gpio_i;
`ifdef GPIO_DEBOUNCE_EN
            new_in = m_in;
            for (int p = 0; p < N; p++) begin
                if (synced[p] != m_in[p]) begin
                    m_cnt[p] = m_cnt[p] + 1;
                    if (m_cnt[p] >= DEB) begin
                        new_in[p] = synced[p];
                        m_cnt[p] = 0;
                    end
                end else begin
                    m_cnt[p] = 0;
                end
            end
`else
            new_in = synced;
`endif
            if (bus_if.bus_re && !bus_if.bus_we) begin
                m_rvalid = 1'b1;
                m_rdata  = model_read(bus_if.bus_addr);
            end else begin
                m_rvalid = 1'b0;
            end
            w1c = (bus_if.bus_we && bus_if.bus_addr == 3'd5) ? bus_if.bus_wdata[N-1:0] : '0;
            m_stat = (m_stat & ~w1c) | (new_in & ~m_in & m_rise) | (~new_in & m_in & m_fall);
            m_in = new_in;
            if (bus_if.bus_we) begin
                case (bus_if.bus_addr)
                    3'd0: m_out  = bus_if.bus_wdata[N-1:0];
                    3'd1: m_dir  = bus_if.bus_wdata[N-1:0];
                    3'd3: m_rise = bus_if.bus_wdata[N-1:0];
                    3'd4: m_fall = bus_if.bus_wdata[N-1:0];
                    3'd6: m_out  = m_out | bus_if.bus_wdata[N-1:0];
                    3'd7: m_out  = m_out & ~bus_if.bus_wdata[N-1:0];
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if ({bus_if.bus_rdata, bus_if.bus_rvalid, irq, gpio_o, gpio_oe} !==
                {m_rdata, m_rvalid, (|m_stat), m_out, m_dir}) begin
                bad++;
                $display("[TB] FAIL model_cmp t=%0t: got rd=%h rv=%b irq=%b o=%h oe=%h, want rd=%h rv=%b irq=%b o=%h oe=%h",
                         $time, bus_if.bus_rdata, bus_if.bus_rvalid, irq, gpio_o, gpio_oe,
                         m_rdata, m_rvalid, (|m_stat), m_out, m_dir);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic re, input logic [2:0] addr,
                                  input logic [31:0] wdata);
        bus_if.bus_we    = we;
        bus_if.bus_re    = re;
        bus_if.bus_addr  = addr;
        bus_if.bus_wdata = wdata;
        tick();
        bus_if.bus_we = 1'b0;
        bus_if.bus_re = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] addr, input logic [31:0] exp, input string name);
        apply_stimulus(1'b0, 1'b1, addr, 32'h0);
        check_output({name, "_rvalid"}, 32'(bus_if.bus_rvalid), 32'h1);
        check_output(name, bus_if.bus_rdata, exp);
        tick();
        check_output({name, "_rvalid_drop"}, 32'(bus_if.bus_rvalid), 32'h0);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_rdata;
        logic [N-1:0] exp_o;
        logic [N-1:0] exp_oe;
    } vec_t;

    vec_t vecs [15];
    int   lat;
    logic seen;

`ifdef GPIO_DEBOUNCE_EN
    task automatic pulse_pin1(input int len, input logic exp_seen, input logic exp_irq);
        gpio_i[1] = 1'b1;
        repeat (len) tick();
        gpio_i[1] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 14; k++) begin
            apply_stimulus(1'b0, 1'b1, 3'd2, 32'h0);
            seen = seen | bus_if.bus_rdata[1];
        end
        check_output($sformatf("t5_datain_pulse%0d", len), 32'(seen), 32'(exp_seen));
        check_output($sformatf("t5_irq_pulse%0d", len), 32'(irq), 32'(exp_irq));
    endtask
`endif

    initial begin
        bus_if.bus_we = 1'b0; bus_if.bus_re = 1'b0;
        bus_if.bus_addr = 3'd0; bus_if.bus_wdata = 32'h0;

        vecs[0]  = '{1'b0, 3'd0, 32'h0,        32'h0,   10'h000, 10'h000};
        vecs[1]  = '{1'b0, 3'd1, 32'h0,        32'h0,   10'h000, 10'h000};
        vecs[2]  = '{1'b0, 3'd3, 32'h0,        32'h0,   10'h000, 10'h000};
        vecs[3]  = '{1'b0, 3'd4, 32'h0,        32'h0,   10'h000, 10'h000};
        vecs[4]  = '{1'b0, 3'd5, 32'h0,        32'h0,   10'h000, 10'h000};
        vecs[5]  = '{1'b1, 3'd1, 32'h00F,      32'h0,   10'h000, 10'h00F};
        vecs[6]  = '{1'b1, 3'd0, 32'h005,      32'h0,   10'h005, 10'h00F};
        vecs[7]  = '{1'b1, 3'd6, 32'h00A,      32'h0,   10'h00F, 10'h00F};
        vecs[8]  = '{1'b1, 3'd7, 32'h001,      32'h0,   10'h00E, 10'h00F};
        vecs[9]  = '{1'b0, 3'd0, 32'h0,        32'h00E, 10'h00E, 10'h00F};
        vecs[10] = '{1'b0, 3'd6, 32'h0,        32'h0,   10'h00E, 10'h00F};
        vecs[11] = '{1'b1, 3'd0, 32'hFFFFFFFF, 32'h0,   10'h3FF, 10'h00F};
        vecs[12] = '{1'b0, 3'd0, 32'h0,        32'h3FF, 10'h3FF, 10'h00F};
        vecs[13] = '{1'b1, 3'd0, 32'h00E,      32'h0,   10'h00E, 10'h00F};
        vecs[14] = '{1'b0, 3'd2, 32'h0,        32'h0,   10'h00E, 10'h00F};

        // Reset held for two edges, then the register/pad table.
        @(negedge clk);
        tick();
        tick();
        chk_en = 1'b1;
        check_output("t1_irq", 32'(irq), 32'h0);
        check_output("t1_rvalid", 32'(bus_if.bus_rvalid), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i].we, ~vecs[i].we, vecs[i].addr, vecs[i].data);
            if (!vecs[i].we) begin
                check_output($sformatf("vec%0d_rvalid", i), 32'(bus_if.bus_rvalid), 32'h1);
                check_output($sformatf("vec%0d_rdata", i), bus_if.bus_rdata, vecs[i].exp_rdata);
            end
            check_output($sformatf("vec%0d_gpio_o", i), 32'(gpio_o), 32'(vecs[i].exp_o));
            check_output($sformatf("vec%0d_gpio_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
            tick();
            check_output($sformatf("vec%0d_rvalid_drop", i), 32'(bus_if.bus_rvalid), 32'h0);
        end

        // Rising edge on pin 3 reaches status after exactly LAT edges.
        apply_stimulus(1'b1, 1'b0, 3'd3, 32'h008);
        gpio_i[3] = 1'b1;
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            tick();
            if (irq) lat = k;
        end
        check_output("t3_irq_latency", 32'(lat), 32'(LAT));
        do_read(3'd5, 32'h008, "t3_status");
        apply_stimulus(1'b1, 1'b0, 3'd5, 32'h008);
        check_output("t3_irq_after_w1c", 32'(irq), 32'h0);

        // W1C landing on the same edge as a new fall on pin 0: the edge wins.
        gpio_i[0] = 1'b1;
        repeat (LAT + 2) tick();
        apply_stimulus(1'b1, 1'b0, 3'd4, 32'h001);
        gpio_i[0] = 1'b0;
        repeat (LAT - 1) tick();
        apply_stimulus(1'b1, 1'b0, 3'd5, 32'h001);
        check_output("t4_irq", 32'(irq), 32'h1);
        do_read(3'd5, 32'h001, "t4_status");

        // Short pulses on pin 1.
        apply_stimulus(1'b1, 1'b0, 3'd3, 32'h002);
        apply_stimulus(1'b1, 1'b0, 3'd5, 32'h3FF);
        check_output("t5_irq_cleared", 32'(irq), 32'h0);
`ifdef GPIO_DEBOUNCE_EN
        pulse_pin1(DEB - 1, 1'b0, 1'b0);
        pulse_pin1(DEB, 1'b1, 1'b1);
        do_read(3'd5, 32'h002, "t5_status");
`else
        gpio_i[1] = 1'b1;
        tick();
        gpio_i[1] = 1'b0;
        repeat (LAT + 1) tick();
        check_output("t5_irq", 32'(irq), 32'h1);
        do_read(3'd5, 32'h002, "t5_status");
`endif

        // Pending status wiped by a reset that lands on a read strobe.
        apply_stimulus(1'b1, 1'b0, 3'd3, 32'h008);
        apply_stimulus(1'b1, 1'b0, 3'd5, 32'h3FF);
        gpio_i[3] = 1'b0;
        repeat (LAT + 2) tick();
        gpio_i[3] = 1'b1;
        repeat (LAT + 2) tick();
        check_output("t6_irq_pending", 32'(irq), 32'h1);
        rst_n = 1'b0;
        apply_stimulus(1'b0, 1'b1, 3'd5, 32'h0);
        rst_n = 1'b1;
        check_output("t6_rvalid", 32'(bus_if.bus_rvalid), 32'h0);
        check_output("t6_irq", 32'(irq), 32'h0);
        repeat (LAT + 2) tick();
        check_output("t6_irq_high_pad", 32'(irq), 32'h0);
        do_read(3'd5, 32'h0, "t6_status");
        do_read(3'd1, 32'h0, "t6_dir");

        // Randomized traffic; the per-cycle model comparison does the checking.
        for (int c = 0; c < 2000; c++) begin
            bus_if.bus_we    = ($urandom_range(0, 3) == 0);
            bus_if.bus_re    = ($urandom_range(0, 2) == 0);
            bus_if.bus_addr  = 3'($urandom_range(0, 7));
            bus_if.bus_wdata = $urandom;
            if ($urandom_range(0, 7) == 0) gpio_i = gpio_i ^ N'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        bus_if.bus_we = 1'b0;
        bus_if.bus_re = 1'b0;
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
